// File: rtl/rd_tag_alloc_pkg.sv
// Shared widths and the tagged request payload for the DRAM-cache read-path tag allocator.
package rd_tag_alloc_pkg;

  localparam int unsigned AXI_ID_WIDTH   = 4;
  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned TID_WIDTH      = 4;

  // TID_MAX must equal 2**TID_WIDTH so that pointer wrap and credit limit coincide
  localparam int unsigned TID_MAX = 16;

  localparam int unsigned CNT_WIDTH = TID_WIDTH + 1;

  typedef struct packed {
    logic [TID_WIDTH-1:0]      tid;
    logic [AXI_ADDR_WIDTH-1:0] addr;
  } tagged_req_t;

endpackage

// File: rtl/rd_tag_alloc_table.sv
// Tag table: one AXI ID per tID, synchronous write at allocation, asynchronous read at retire.
module rd_tag_table
  import rd_tag_alloc_pkg::*;
#(
  parameter int unsigned AW = TID_WIDTH,
  parameter int unsigned DW = AXI_ID_WIDTH
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset; every entry is written before it can be retired
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rd_tag_alloc.sv
// AR-channel tag allocator: stamps each read with a sequential tID, records its AXI ID,
// and recycles tags in order on ROB retire. RD_TAG_ALLOC_PERF_EN adds stall/peak counters.
module rd_tag_alloc
  import rd_tag_alloc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arvalid_i,
  output logic                      arready_o,
  input  logic [AXI_ID_WIDTH-1:0]   arid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr_i,
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output logic [TID_WIDTH-1:0]      req_tid_o,
  output logic [AXI_ADDR_WIDTH-1:0] req_addr_o,
  input  logic                      retire_valid_i,
  input  logic [TID_WIDTH-1:0]      retire_tid_i,
  output logic [AXI_ID_WIDTH-1:0]   retire_rid_o,
  output logic [CNT_WIDTH-1:0]      outstanding_o,
  output logic                      order_err_o
`ifdef RD_TAG_ALLOC_PERF_EN
  ,
  output logic [31:0]               stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      peak_outstanding_o
`endif
);

  logic [TID_WIDTH-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [TID_WIDTH-1:0] retire_ptr_q, retire_ptr_d;
  logic [CNT_WIDTH-1:0] outstanding_q, outstanding_d;
  logic                 req_valid_q, req_valid_d;
  tagged_req_t          req_q, req_d;
  logic                 order_err_q, order_err_d;

  logic credit_ok;
  logic slot_free;
  logic accept;
  logic legal_retire;

  // Credit uses only registered state, so a retire frees its credit one cycle later
  always_comb begin
    credit_ok    = outstanding_q < CNT_WIDTH'(TID_MAX);
    slot_free    = !req_valid_q || req_ready_i;
    arready_o    = credit_ok && slot_free;
    accept       = arvalid_i && arready_o;
    legal_retire = retire_valid_i && (outstanding_q != '0) && (retire_tid_i == retire_ptr_q);
  end

  always_comb begin
    alloc_ptr_d   = alloc_ptr_q;
    retire_ptr_d  = retire_ptr_q;
    req_valid_d   = req_valid_q;
    req_d         = req_q;
    order_err_d   = order_err_q;
    outstanding_d = outstanding_q + CNT_WIDTH'(accept) - CNT_WIDTH'(legal_retire);

    if (accept) begin
      req_valid_d = 1'b1;
      req_d.tid   = alloc_ptr_q;
      req_d.addr  = araddr_i;
      alloc_ptr_d = alloc_ptr_q + TID_WIDTH'(1);
    end else if (req_valid_q && req_ready_i) begin
      req_valid_d = 1'b0;
    end

    if (legal_retire) begin
      retire_ptr_d = retire_ptr_q + TID_WIDTH'(1);
    end else if (retire_valid_i) begin
      order_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr_q   <= '0;
      retire_ptr_q  <= '0;
      outstanding_q <= '0;
      req_valid_q   <= 1'b0;
      req_q         <= '0;
      order_err_q   <= 1'b0;
    end else begin
      alloc_ptr_q   <= alloc_ptr_d;
      retire_ptr_q  <= retire_ptr_d;
      outstanding_q <= outstanding_d;
      req_valid_q   <= req_valid_d;
      req_q         <= req_d;
      order_err_q   <= order_err_d;
    end
  end

  rd_tag_table #(
    .AW(TID_WIDTH),
    .DW(AXI_ID_WIDTH)
  ) u_table (
    .clk    (clk),
    .we_i   (accept),
    .waddr_i(alloc_ptr_q),
    .wdata_i(arid_i),
    .raddr_i(retire_tid_i),
    .rdata_o(retire_rid_o)
  );

  assign req_valid_o   = req_valid_q;
  assign req_tid_o     = req_q.tid;
  assign req_addr_o    = req_q.addr;
  assign outstanding_o = outstanding_q;
  assign order_err_o   = order_err_q;

`ifdef RD_TAG_ALLOC_PERF_EN
  logic [31:0]          stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] peak_q, peak_d;

  // Both counters saturate; the peak tracks the post-edge occupancy
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    peak_d      = peak_q;
    if (arvalid_i && !arready_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'(1);
    end
    if (outstanding_d > peak_q) begin
      peak_d = outstanding_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      peak_q      <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      peak_q      <= peak_d;
    end
  end

  assign stall_cnt_o        = stall_cnt_q;
  assign peak_outstanding_o = peak_q;
`endif

endmodule

// File: tb/tb_rd_tag_alloc.sv
// Scoreboard bench for rd_tag_alloc: an in-order queue model predicts tags, IDs, credit and errors.
module tb_rd_tag_alloc;
  import rd_tag_alloc_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      arvalid_i;
  logic                      arready_o;
  logic [AXI_ID_WIDTH-1:0]   arid_i;
  logic [AXI_ADDR_WIDTH-1:0] araddr_i;
  logic                      req_valid_o;
  logic                      req_ready_i;
  logic [TID_WIDTH-1:0]      req_tid_o;
  logic [AXI_ADDR_WIDTH-1:0] req_addr_o;
  logic                      retire_valid_i;
  logic [TID_WIDTH-1:0]      retire_tid_i;
  logic [AXI_ID_WIDTH-1:0]   retire_rid_o;
  logic [CNT_WIDTH-1:0]      outstanding_o;
  logic                      order_err_o;
`ifdef RD_TAG_ALLOC_PERF_EN
  logic [31:0]               stall_cnt_o;
  logic [CNT_WIDTH-1:0]      peak_outstanding_o;
`endif

  always #5 clk = ~clk;

  rd_tag_alloc dut (
    .clk           (clk),
    .rst           (rst),
    .arvalid_i     (arvalid_i),
    .arready_o     (arready_o),
    .arid_i        (arid_i),
    .araddr_i      (araddr_i),
    .req_valid_o   (req_valid_o),
    .req_ready_i   (req_ready_i),
    .req_tid_o     (req_tid_o),
    .req_addr_o    (req_addr_o),
    .retire_valid_i(retire_valid_i),
    .retire_tid_i  (retire_tid_i),
    .retire_rid_o  (retire_rid_o),
    .outstanding_o (outstanding_o),
    .order_err_o   (order_err_o)
`ifdef RD_TAG_ALLOC_PERF_EN
    ,
    .stall_cnt_o       (stall_cnt_o),
    .peak_outstanding_o(peak_outstanding_o)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: in-flight IDs in allocation order, plus counters
  tagged_req_t exp_q[$];
  int          id_q[$];
  int          m_out, m_alloc, m_retire, m_pend;
  bit          m_err;
  longint      m_stall;
  int          m_peak;
  tagged_req_t mon_e;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    id_q.delete();
    m_out = 0; m_alloc = 0; m_retire = 0; m_pend = 0;
    m_err = 0; m_stall = 0; m_peak = 0;
  endfunction

  // Monitor: every output transfer must match the oldest issued request
  always @(negedge clk) begin
    if (!rst && req_valid_o && req_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("req_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("req_tid", 64'(req_tid_o), 64'(mon_e.tid));
        chk("req_addr", 64'(req_addr_o), 64'(mon_e.addr));
      end
    end
  end

  task automatic step(input bit av, input int id, input longint addr,
                      input bit rr, input bit rv, input int rt);
    bit exp_ar, acc, legal, xfer;
    tagged_req_t e;
    @(posedge clk);
    #1;
    arvalid_i      = av;
    arid_i         = AXI_ID_WIDTH'(id);
    araddr_i       = AXI_ADDR_WIDTH'(addr);
    req_ready_i    = rr;
    retire_valid_i = rv;
    retire_tid_i   = TID_WIDTH'(rt);
    #1;
    exp_ar = (m_out < int'(TID_MAX)) && (m_pend == 0 || rr);
    chk("arready", 64'(arready_o), 64'(exp_ar));
    chk("outstanding", 64'(outstanding_o), 64'(m_out));
    chk("order_err", 64'(order_err_o), 64'(m_err));
    chk("req_valid", 64'(req_valid_o), 64'(m_pend != 0));
`ifdef RD_TAG_ALLOC_PERF_EN
    chk("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
    chk("peak_outstanding", 64'(peak_outstanding_o), 64'(m_peak));
`endif
    acc   = av && exp_ar;
    legal = rv && (m_out > 0) && (rt == m_retire);
    if (legal) begin
      chk("retire_rid", 64'(retire_rid_o), 64'(id_q[0]));
      void'(id_q.pop_front());
      m_retire = (m_retire + 1) % int'(TID_MAX);
    end else if (rv) begin
      m_err = 1;
    end
    xfer   = (m_pend != 0) && rr;
    m_pend = m_pend - int'(xfer) + int'(acc);
    if (acc) begin
      e.tid  = TID_WIDTH'(m_alloc);
      e.addr = AXI_ADDR_WIDTH'(addr);
      exp_q.push_back(e);
      id_q.push_back(id);
      m_alloc = (m_alloc + 1) % int'(TID_MAX);
    end
    m_out = m_out + int'(acc) - int'(legal);
    if (av && !exp_ar && m_stall != 64'hFFFF_FFFF) m_stall++;
    if (m_out > m_peak) m_peak = m_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0);
  endtask

  task automatic drain_retire();
    while (m_out > 0) step(0, 0, 0, 1, 1, m_retire);
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_valid", 64'(req_valid_o), 64'd0);
    chk("rst_req_tid", 64'(req_tid_o), 64'd0);
    chk("rst_req_addr", 64'(req_addr_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_order_err", 64'(order_err_o), 64'd0);
`ifdef RD_TAG_ALLOC_PERF_EN
    chk("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
    chk("rst_peak", 64'(peak_outstanding_o), 64'd0);
`endif
  endtask

  // Reset asserted between clock edges; outputs must clear without an edge
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    arvalid_i = 0; arid_i = '0; araddr_i = '0; req_ready_i = 1;
    retire_valid_i = 0; retire_tid_i = '0;
    model_reset();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single request and its retire
    step(1, 3, 64'h1000, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    idle(2);

    // Fill all tags, back-pressure, then free one and reuse tag 0
    async_reset();
    for (int i = 0; i < int'(TID_MAX); i++) step(1, i, 64'h100 * i, 1, 0, 0);
    step(1, 1, 64'hDEAD0, 1, 0, 0);
    step(1, 2, 64'hBEEF0, 1, 1, 0);
    step(1, 9, 64'hABC0, 1, 0, 0);
    idle(1);
    drain_retire();

    // Output stall while holding a request
    step(1, 5, 64'h2000, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 6, 64'h2040, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    drain_retire();

    // Accept and retire in the same cycle at 8 outstanding
    for (int i = 0; i < 8; i++) step(1, i + 2, 64'h3000 + i, 1, 0, 0);
    step(1, 7, 64'h3100, 1, 1, m_retire);
    step(0, 0, 0, 1, 0, 0);
    drain_retire();

    // Out-of-order retire and retire while empty
    for (int i = 0; i < 4; i++) step(1, i, 64'h4000 + i, 1, 0, 0);
    step(0, 0, 0, 1, 1, (m_retire + 3) % int'(TID_MAX));
    idle(1);
    drain_retire();
    step(0, 0, 0, 1, 1, m_retire);
    idle(2);

    // Async reset with six in flight, next request restarts at tag 0
    for (int i = 0; i < 6; i++) step(1, i, 64'h5000 + i, 1, 0, 0);
    arvalid_i = 0; retire_valid_i = 0;
    async_reset();
    step(1, 7, 64'h6000, 1, 0, 0);
    idle(1);
    drain_retire();

    // Randomized traffic in three pressure regimes
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 600; c++) begin
        bit av, rr, rv;
        int rt;
        av = ($urandom % 4) < (ph == 0 ? 3 : 2);
        rr = ($urandom % 4) < (ph == 1 ? 1 : 3);
        rv = ($urandom % 8) < (ph == 0 ? 1 : 4);
        rt = (ph == 2 && ($urandom % 32 == 0)) ? int'($urandom % TID_MAX) : m_retire;
        step(av, int'($urandom % (1 << AXI_ID_WIDTH)), longint'($urandom), rr, rv, rt);
      end
    end

    idle(3);
    drain_retire();
    idle(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rd_tag_alloc.md
Name: rd_tag_alloc

Overview:
- Front stage of the DRAM-cache read path, directly upstream of the tag-compare / reorder buffer pair.
- Accepts AXI read requests (AR channel) and stamps each with a sequential transaction tag (tID). Forwards {tID, addr} to tag compare.
- Records the AXI ID of each request in a tag table indexed by tID.
- Recycles tags in order when the reorder buffer retires a response, and returns the original ID for the R channel.

Parameters:
ID_WIDTH, `AXI_ID_WIDTH, AXI ID width
ADDR_WIDTH, `AXI_ADDR_WIDTH, request address width
TID_WIDTH, `TID_WIDTH, tag width (default 4)
TID_MAX, `TID_MAX, max outstanding tags; must equal 2**TID_WIDTH (default 16)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
arvalid_i  in  1  AXI read request valid
arready_o  out  1  AXI read request ready
arid_i  in  ID_WIDTH  AXI request ID
araddr_i  in  ADDR_WIDTH  AXI request address
req_valid_o  out  1  tagged request valid to tag compare
req_ready_i  in  1  tag compare ready
req_tid_o  out  TID_WIDTH  assigned tID
req_addr_o  out  ADDR_WIDTH  request address
retire_valid_i  in  1  ROB retires one response this cycle
retire_tid_i  in  TID_WIDTH  tID being retired
retire_rid_o  out  ID_WIDTH  AXI ID stored for retire_tid_i (combinational)
outstanding_o  out  TID_WIDTH+1  tags currently in flight
order_err_o  out  1  sticky in-order retire violation

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: req_valid_o=0, req_tid_o=0, req_addr_o=0, alloc_ptr=0, retire_ptr=0, outstanding_o=0, order_err_o=0. Tag table contents are not reset.
- Credit: credit_ok = (outstanding_o < TID_MAX).
- Output register: a single-entry output register, slot_free = !req_valid_o | req_ready_i.
  - arready_o = credit_ok & slot_free. This is combinational and does not depend on arvalid_i.
- Accept: accept = arvalid_i & arready_o. On accept, the next edge does all of the following:
  - req_valid_o<=1, req_tid_o<=alloc_ptr, req_addr_o<=araddr_i.
  - table[alloc_ptr]<=arid_i.
  - alloc_ptr<=alloc_ptr+1, wrapping modulo 2**TID_WIDTH.
- Output handshake: if req_valid_o & req_ready_i & !accept, then req_valid_o<=0. Output is held stable while req_valid_o & !req_ready_i.
- Latency: one cycle, AR accept to req_valid_o. Back-to-back accepts sustain one request per cycle when req_ready_i=1.
- Retire (in order only): a retire is legal when retire_valid_i & outstanding_o!=0 & retire_tid_i==retire_ptr.
  - Legal retire: retire_ptr<=retire_ptr+1 (wrap).
  - retire_rid_o = table[retire_tid_i] in the same cycle.
- Illegal retire: retire_valid_i with a tID mismatch or with outstanding_o==0.
  - Sets order_err_o<=1 (sticky until rst).
  - Pointers and count are unchanged.
- Counter: outstanding_o<=outstanding_o + accept - legal_retire.
  - Simultaneous accept and legal retire leaves the count unchanged.
  - At outstanding_o==TID_MAX with a same-cycle retire, arready_o stays 0. The new credit appears next cycle; there is no combinational retire-to-arready path.
- Full/empty:
  - At TID_MAX outstanding, AR is back-pressured indefinitely.
  - At 0 outstanding, a retire is an error.
  - Pointer wrap from TID_MAX-1 to 0 is seamless.
- Reset mid-operation: all in-flight tags are dropped. Upstream and the ROB must be reset together.

Optional Feature:
RD_TAG_ALLOC_PERF_EN
- With the macro defined, add outputs:
  - stall_cnt_o (32b): counts cycles where arvalid_i & !arready_o.
  - peak_outstanding_o (TID_WIDTH+1): high-water mark of outstanding_o.
  - Both reset to 0 and saturate; they do not wrap.
- Without the macro, these ports and registers do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package/TYPEDEF.svh: TID_WIDTH, TID_MAX, AXI_ID_WIDTH, AXI_ADDR_WIDTH, and the typedef tagged_req_t {tid, addr}.
- One natural sub-module: rd_tag_table, a 2**TID_WIDTH x ID_WIDTH register file with one sync write port and one async read port.
- Pointers, credit and output register stay in the top module.

Test Plan:
1. Reset, then single AR (arid=3, addr=0x1000) with req_ready_i=1 -> next cycle req_valid_o=1, req_tid_o=0, req_addr_o=0x1000, outstanding_o=1. Retire tid 0 -> retire_rid_o=3, outstanding_o=0.
2. 16 back-to-back ARs with no retire -> tIDs 0..15 issued, outstanding_o=16, arready_o=0 on the 17th. One retire of tid 0 -> arready_o=1 the following cycle; the next request gets tid 0 (wrap).
3. req_ready_i=0 for 5 cycles during an accept -> req_tid_o and req_addr_o held constant, arready_o=0. Release -> exactly one transfer, no loss or duplicate.
4. Simultaneous accept and legal retire at outstanding_o=8 -> outstanding_o stays 8; alloc_ptr and retire_ptr both advance.
5. Retire tid 5 while retire_ptr=2, and separately retire at outstanding_o=0 -> order_err_o=1 and sticky; counts and pointers unchanged.
6. Assert rst asynchronously mid-burst with 6 outstanding -> all outputs zero immediately without waiting for a clock edge. The next accepted request gets tid 0. With RD_TAG_ALLOC_PERF_EN, stall_cnt_o and peak_outstanding_o read 0.
